// File: rtl/branch_skip_sequencer.sv
// rtl/branch_skip_sequencer.sv - multi-cycle instruction sequencer with compare/skip branching
// Optional MEM_TIMEOUT_EN: bounded memory waits that halt with Fault after 15 idle cycles.
module branch_skip_sequencer (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] Opcode,
  input  logic [3:0] funct,
  input  logic       skip,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       AccWrite,
  output logic       CmpEn,
  output logic [2:0] State,
  output logic       Halted,
  output logic       Fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_SKIP   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic is_cmp, is_load, is_store, is_jump, is_halt;

  always_comb begin
    is_cmp   = (Opcode == 4'd10) || (Opcode == 4'd13) || (Opcode == 4'd14) ||
               ((Opcode == 4'd0) && ((funct == 4'd3) || (funct == 4'd11) ||
                                     (funct == 4'd12) || (funct == 4'd15)));
    is_load  = (Opcode == 4'd1);
    is_store = (Opcode == 4'd2);
    is_jump  = (Opcode == 4'd3);
    is_halt  = (Opcode == 4'd15);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        if (is_halt)      state_d = S_HALT;
        else if (is_jump) state_d = S_FETCH;
        else              state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_cmp)                   state_d = skip ? S_SKIP : S_FETCH;
        else if (is_load || is_store) state_d = S_MEM;
        else                          state_d = S_WB;
      end
      S_MEM:    if (MemReady) state_d = is_load ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_SKIP:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [3:0] wait_q;
  logic       fault_q;
  logic       waiting;

  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !MemReady;

  // A waiting state never changes state, so the counter only needs clearing when not waiting.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= S_FETCH;
      wait_q  <= 4'd0;
      fault_q <= 1'b0;
    end else if (waiting && (wait_q == 4'd14)) begin
      state_q <= S_HALT;
      wait_q  <= 4'd0;
      fault_q <= 1'b1;
    end else begin
      state_q <= state_d;
      wait_q  <= waiting ? (wait_q + 4'd1) : 4'd0;
    end
  end

  assign Fault = fault_q;
`else
  always_ff @(posedge CLK) begin
    if (!Reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign Fault = 1'b0;
`endif

  // Enables are gated by Reset so a pending memory access drops in the reset cycle itself.
  always_comb begin
    PCWrite  = 1'b0;
    PCSrc    = 2'd0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    AccWrite = 1'b0;
    CmpEn    = 1'b0;
    if (Reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          if (MemReady) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            PCSrc   = 2'd0;
          end
        end
        S_DECODE: begin
          CmpEn = 1'b1;
          if (is_jump) begin
            PCWrite = 1'b1;
            PCSrc   = 2'd2;
          end
        end
        S_MEM: begin
          if (is_load)       MemRead  = 1'b1;
          else if (is_store) MemWrite = 1'b1;
        end
        S_WB:   AccWrite = 1'b1;
        S_SKIP: begin
          PCWrite = 1'b1;
          PCSrc   = 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign State  = state_q;
  assign Halted = Reset && (state_q == S_HALT);

endmodule

// File: tb/tb_branch_skip_sequencer.sv
// tb/tb_branch_skip_sequencer.sv - scoreboard bench for branch_skip_sequencer
module tb_branch_skip_sequencer;

  logic       CLK;
  logic       Reset;
  logic [3:0] Opcode;
  logic [3:0] funct;
  logic       skip;
  logic       MemReady;
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic       IRWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       AccWrite;
  logic       CmpEn;
  logic [2:0] State;
  logic       Halted;
  logic       Fault;

  branch_skip_sequencer dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .funct(funct), .skip(skip),
    .MemReady(MemReady), .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .AccWrite(AccWrite), .CmpEn(CmpEn),
    .State(State), .Halted(Halted), .Fault(Fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Observation vector: {State, PCWrite, PCSrc, IRWrite, MemRead, MemWrite, AccWrite, CmpEn, Halted, Fault}
  localparam logic [12:0] F_RST     = 13'b000_0_00_0_0_0_0_0_0_0;
  localparam logic [12:0] F_GO      = 13'b000_1_00_1_1_0_0_0_0_0;
  localparam logic [12:0] F_WAIT    = 13'b000_0_00_0_1_0_0_0_0_0;
  localparam logic [12:0] DEC       = 13'b001_0_00_0_0_0_0_1_0_0;
  localparam logic [12:0] JMPD      = 13'b001_1_10_0_0_0_0_1_0_0;
  localparam logic [12:0] EXE       = 13'b010_0_00_0_0_0_0_0_0_0;
  localparam logic [12:0] MEM_R     = 13'b011_0_00_0_1_0_0_0_0_0;
  localparam logic [12:0] MEM_W     = 13'b011_0_00_0_0_1_0_0_0_0;
  localparam logic [12:0] MEM_X     = 13'b011_0_00_0_0_0_0_0_0_0;
  localparam logic [12:0] WBV       = 13'b100_0_00_0_0_0_1_0_0_0;
  localparam logic [12:0] SKP       = 13'b101_1_01_0_0_0_0_0_0_0;
  localparam logic [12:0] HLT       = 13'b110_0_00_0_0_0_0_0_1_0;
  localparam logic [12:0] HLT_RST   = 13'b110_0_00_0_0_0_0_0_0_0;
  localparam logic [12:0] HLT_F     = 13'b110_0_00_0_0_0_0_0_1_1;
  localparam logic [12:0] HLT_F_RST = 13'b110_0_00_0_0_0_0_0_0_1;

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic [3:0]  fn;
    logic        sk;
    logic        mr;
    logic [12:0] exp;
  } stim_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [12:0] exp_q[$];

  function automatic stim_t st(input logic rst, input logic [3:0] op, input logic [3:0] fn,
                               input logic sk, input logic mr, input logic [12:0] exp);
    stim_t s;
    s.rst = rst; s.op = op; s.fn = fn; s.sk = sk; s.mr = mr; s.exp = exp;
    return s;
  endfunction

  function automatic logic [12:0] obs();
    return {State, PCWrite, PCSrc, IRWrite, MemRead, MemWrite, AccWrite, CmpEn, Halted, Fault};
  endfunction

  task automatic test_reset();
    stim_t s[$];
    logic [12:0] got, want;
    s.push_back(st(0, 4'd1, 4'd0, 0, 1, F_RST));
    s.push_back(st(0, 4'd2, 4'd0, 0, 1, F_RST));
    foreach (s[i]) begin
      Reset = s[i].rst; Opcode = s[i].op; funct = s[i].fn; skip = s[i].sk; MemReady = s[i].mr;
      exp_q.push_back(s[i].exp);
      @(negedge CLK);
      got = obs(); want = exp_q.pop_front(); n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL reset cyc %0d got %b want %b", i, got, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_cmp_skip();
    stim_t s[$];
    logic [12:0] got, want;
    s.push_back(st(1, 4'd0, 4'd11, 1, 1, F_GO));
    s.push_back(st(1, 4'd0, 4'd11, 1, 1, DEC));
    s.push_back(st(1, 4'd0, 4'd11, 1, 1, EXE));
    s.push_back(st(1, 4'd0, 4'd11, 1, 1, SKP));
    s.push_back(st(1, 4'd0, 4'd11, 1, 0, F_WAIT));
    foreach (s[i]) begin
      Reset = s[i].rst; Opcode = s[i].op; funct = s[i].fn; skip = s[i].sk; MemReady = s[i].mr;
      exp_q.push_back(s[i].exp);
      @(negedge CLK);
      got = obs(); want = exp_q.pop_front(); n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL cmp_skip cyc %0d got %b want %b", i, got, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_cmp_noskip();
    stim_t s[$];
    logic [12:0] got, want;
    s.push_back(st(1, 4'd13, 4'd0, 0, 1, F_GO));
    s.push_back(st(1, 4'd13, 4'd0, 0, 1, DEC));
    s.push_back(st(1, 4'd13, 4'd0, 0, 1, EXE));
    s.push_back(st(1, 4'd13, 4'd0, 0, 0, F_WAIT));
    foreach (s[i]) begin
      Reset = s[i].rst; Opcode = s[i].op; funct = s[i].fn; skip = s[i].sk; MemReady = s[i].mr;
      exp_q.push_back(s[i].exp);
      @(negedge CLK);
      got = obs(); want = exp_q.pop_front(); n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL cmp_noskip cyc %0d got %b want %b", i, got, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_load_wait();
    stim_t s[$];
    logic [12:0] got, want;
    s.push_back(st(1, 4'd1, 4'd0, 0, 1, F_GO));
    s.push_back(st(1, 4'd1, 4'd0, 0, 1, DEC));
    s.push_back(st(1, 4'd1, 4'd0, 0, 1, EXE));
    s.push_back(st(1, 4'd1, 4'd0, 0, 0, MEM_R));
    s.push_back(st(1, 4'd1, 4'd0, 0, 0, MEM_R));
    s.push_back(st(1, 4'd1, 4'd0, 0, 0, MEM_R));
    s.push_back(st(1, 4'd1, 4'd0, 0, 1, MEM_R));
    s.push_back(st(1, 4'd1, 4'd0, 0, 1, WBV));
    s.push_back(st(1, 4'd1, 4'd0, 0, 0, F_WAIT));
    foreach (s[i]) begin
      Reset = s[i].rst; Opcode = s[i].op; funct = s[i].fn; skip = s[i].sk; MemReady = s[i].mr;
      exp_q.push_back(s[i].exp);
      @(negedge CLK);
      got = obs(); want = exp_q.pop_front(); n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL load_wait cyc %0d got %b want %b", i, got, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_alu();
    stim_t s[$];
    logic [12:0] got, want;
    // Opcode 0 with a non-compare funct is ALU even with skip asserted
    s.push_back(st(1, 4'd0, 4'd4, 1, 1, F_GO));
    s.push_back(st(1, 4'd0, 4'd4, 1, 1, DEC));
    s.push_back(st(1, 4'd0, 4'd4, 1, 1, EXE));
    s.push_back(st(1, 4'd0, 4'd4, 1, 1, WBV));
    s.push_back(st(1, 4'd7, 4'd0, 1, 1, F_GO));
    s.push_back(st(1, 4'd7, 4'd0, 1, 1, DEC));
    s.push_back(st(1, 4'd7, 4'd0, 1, 1, EXE));
    s.push_back(st(1, 4'd7, 4'd0, 1, 1, WBV));
    s.push_back(st(1, 4'd7, 4'd0, 0, 0, F_WAIT));
    foreach (s[i]) begin
      Reset = s[i].rst; Opcode = s[i].op; funct = s[i].fn; skip = s[i].sk; MemReady = s[i].mr;
      exp_q.push_back(s[i].exp);
      @(negedge CLK);
      got = obs(); want = exp_q.pop_front(); n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL alu cyc %0d got %b want %b", i, got, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_jump();
    stim_t s[$];
    logic [12:0] got, want;
    s.push_back(st(1, 4'd3, 4'd0, 0, 1, F_GO));
    s.push_back(st(1, 4'd3, 4'd0, 0, 1, JMPD));
    s.push_back(st(1, 4'd3, 4'd0, 0, 0, F_WAIT));
    foreach (s[i]) begin
      Reset = s[i].rst; Opcode = s[i].op; funct = s[i].fn; skip = s[i].sk; MemReady = s[i].mr;
      exp_q.push_back(s[i].exp);
      @(negedge CLK);
      got = obs(); want = exp_q.pop_front(); n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL jump cyc %0d got %b want %b", i, got, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_fetch_opcode_ignored();
    stim_t s[$];
    logic [12:0] got, want;
    s.push_back(st(1, 4'd15, 4'd0, 0, 0, F_WAIT));
    s.push_back(st(1, 4'd3,  4'd0, 0, 0, F_WAIT));
    s.push_back(st(1, 4'd15, 4'd0, 0, 1, F_GO));
    s.push_back(st(1, 4'd10, 4'd0, 0, 1, DEC));
    s.push_back(st(1, 4'd10, 4'd0, 0, 1, EXE));
    s.push_back(st(1, 4'd10, 4'd0, 0, 0, F_WAIT));
    foreach (s[i]) begin
      Reset = s[i].rst; Opcode = s[i].op; funct = s[i].fn; skip = s[i].sk; MemReady = s[i].mr;
      exp_q.push_back(s[i].exp);
      @(negedge CLK);
      got = obs(); want = exp_q.pop_front(); n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL fetch_ignore cyc %0d got %b want %b", i, got, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_halt();
    stim_t s[$];
    logic [12:0] got, want;
    s.push_back(st(1, 4'd15, 4'd0, 0, 1, F_GO));
    s.push_back(st(1, 4'd15, 4'd0, 0, 1, DEC));
    for (int k = 0; k < 10; k++) s.push_back(st(1, 4'(k), 4'd0, 1, k[0], HLT));
    s.push_back(st(0, 4'd15, 4'd0, 0, 1, HLT_RST));
    s.push_back(st(1, 4'd15, 4'd0, 0, 0, F_WAIT));
    foreach (s[i]) begin
      Reset = s[i].rst; Opcode = s[i].op; funct = s[i].fn; skip = s[i].sk; MemReady = s[i].mr;
      exp_q.push_back(s[i].exp);
      @(negedge CLK);
      got = obs(); want = exp_q.pop_front(); n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL halt cyc %0d got %b want %b", i, got, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_store_reset();
    stim_t s[$];
    logic [12:0] got, want;
    s.push_back(st(1, 4'd2, 4'd0, 0, 1, F_GO));
    s.push_back(st(1, 4'd2, 4'd0, 0, 1, DEC));
    s.push_back(st(1, 4'd2, 4'd0, 0, 1, EXE));
    s.push_back(st(1, 4'd2, 4'd0, 0, 1, MEM_W));
    s.push_back(st(1, 4'd2, 4'd0, 0, 1, F_GO));
    s.push_back(st(1, 4'd2, 4'd0, 0, 1, DEC));
    s.push_back(st(1, 4'd2, 4'd0, 0, 1, EXE));
    s.push_back(st(1, 4'd2, 4'd0, 0, 0, MEM_W));
    s.push_back(st(0, 4'd2, 4'd0, 0, 0, MEM_X));
    s.push_back(st(1, 4'd2, 4'd0, 0, 0, F_WAIT));
    foreach (s[i]) begin
      Reset = s[i].rst; Opcode = s[i].op; funct = s[i].fn; skip = s[i].sk; MemReady = s[i].mr;
      exp_q.push_back(s[i].exp);
      @(negedge CLK);
      got = obs(); want = exp_q.pop_front(); n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL store_reset cyc %0d got %b want %b", i, got, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    logic [12:0] got, want;
    s.push_back(st(1, 4'd14, 4'd0,  1, 1, F_GO));
    s.push_back(st(1, 4'd14, 4'd0,  1, 1, DEC));
    s.push_back(st(1, 4'd14, 4'd0,  1, 1, EXE));
    s.push_back(st(1, 4'd14, 4'd0,  1, 1, SKP));
    s.push_back(st(1, 4'd0,  4'd15, 0, 1, F_GO));
    s.push_back(st(1, 4'd0,  4'd15, 0, 1, DEC));
    s.push_back(st(1, 4'd0,  4'd15, 0, 1, EXE));
    s.push_back(st(1, 4'd0,  4'd12, 1, 1, F_GO));
    s.push_back(st(1, 4'd0,  4'd12, 1, 1, DEC));
    s.push_back(st(1, 4'd0,  4'd12, 1, 1, EXE));
    s.push_back(st(1, 4'd0,  4'd12, 1, 1, SKP));
    s.push_back(st(1, 4'd0,  4'd12, 1, 0, F_WAIT));
    foreach (s[i]) begin
      Reset = s[i].rst; Opcode = s[i].op; funct = s[i].fn; skip = s[i].sk; MemReady = s[i].mr;
      exp_q.push_back(s[i].exp);
      @(negedge CLK);
      got = obs(); want = exp_q.pop_front(); n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL back_to_back cyc %0d got %b want %b", i, got, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_timeout();
    stim_t s[$];
    logic [12:0] got, want;
    s.push_back(st(0, 4'd5, 4'd0, 0, 0, F_RST));
`ifdef MEM_TIMEOUT_EN
    for (int k = 0; k < 15; k++) s.push_back(st(1, 4'd5, 4'd0, 0, 0, F_WAIT));
    s.push_back(st(1, 4'd5, 4'd0, 0, 0, HLT_F));
    s.push_back(st(1, 4'd5, 4'd0, 0, 1, HLT_F));
    s.push_back(st(0, 4'd5, 4'd0, 0, 0, HLT_F_RST));
`else
    for (int k = 0; k < 40; k++) s.push_back(st(1, 4'd5, 4'd0, 0, 0, F_WAIT));
    s.push_back(st(0, 4'd5, 4'd0, 0, 0, F_RST));
`endif
    s.push_back(st(1, 4'd5, 4'd0, 0, 0, F_WAIT));
    foreach (s[i]) begin
      Reset = s[i].rst; Opcode = s[i].op; funct = s[i].fn; skip = s[i].sk; MemReady = s[i].mr;
      exp_q.push_back(s[i].exp);
      @(negedge CLK);
      got = obs(); want = exp_q.pop_front(); n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL timeout cyc %0d got %b want %b", i, got, want); end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    Reset = 1'b0; Opcode = 4'd0; funct = 4'd0; skip = 1'b0; MemReady = 1'b1;
    @(posedge CLK); #1;
    test_reset();
    test_cmp_skip();
    test_cmp_noskip();
    test_load_wait();
    test_alu();
    test_jump();
    test_fetch_opcode_ignored();
    test_halt();
    test_store_reset();
    test_back_to_back();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
